// File: rtl/hazard_ctl.sv
// hazard_ctl: RF-stage operand forwarding selects and load-use stall control.
// Ports: clk, rst_i (async, active-high); RF instr rs/rt/rd fields + flags;
//   hold_i (freeze), flush_i (discard); fw_cmp_rs/fw_cmp_rt, stall_o, busy_o.
// Build option: HAZ_STAT_EN adds stall_cnt_o/fwd_cnt_o saturating counters.
module hazard_ctl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter logic [2:0]  FW_RF    = 3'd0,
  parameter logic [2:0]  FW_ALU   = 3'd1,
  parameter logic [2:0]  FW_MEM   = 3'd2
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [4:0] rs_n_i,
  input  logic [4:0] rt_n_i,
  input  logic       rs_use_i,
  input  logic       rt_use_i,
  input  logic [4:0] rd_index_i,
  input  logic       rd_we_i,
  input  logic       rd_ld_i,
  input  logic       hold_i,
  input  logic       flush_i,
  output logic [2:0] fw_cmp_rs,
  output logic [2:0] fw_cmp_rt,
  output logic       stall_o,
  output logic       busy_o
`ifdef HAZ_STAT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] fwd_cnt_o
`endif
);

  localparam logic RUN   = 1'b0;
  localparam logic STALL = 1'b1;

  // A load in MEM is still not forwardable when data trails by 2 cycles.
  localparam logic MEM_LATE = (LOAD_LAT == 2);
  // Stall counter start value: LOAD_LAT-1 (0 or 1).
  localparam logic CNT_INIT = (LOAD_LAT == 2);

  logic [4:0] ex_rd_q;
  logic       ex_we_q;
  logic       ex_ld_q;
  logic [4:0] mem_rd_q;
  logic       mem_we_q;
  logic       mem_ld_q;

  logic       state_q;
  logic       state_d;
  logic       cnt_q;
  logic       cnt_d;

  logic       rs_act;
  logic       rt_act;
  logic       ex_rs;
  logic       ex_rt;
  logic       mem_rs;
  logic       mem_rt;
  logic       haz_rs;
  logic       haz_rt;
  logic       bubble;

  function automatic logic [2:0] fw_sel(
    input logic act,
    input logic ex_hit,
    input logic mem_hit
  );
    if (!act)
      return FW_RF;
    else if (ex_hit)
      return FW_ALU;
    else if (mem_hit)
      return FW_MEM;
    else
      return FW_RF;
  endfunction

  always_comb begin
    rs_act = rs_use_i & (|rs_n_i);
    rt_act = rt_use_i & (|rt_n_i);
    ex_rs  = ex_we_q & (ex_rd_q == rs_n_i);
    ex_rt  = ex_we_q & (ex_rd_q == rt_n_i);
    mem_rs = mem_we_q & (mem_rd_q == rs_n_i);
    mem_rt = mem_we_q & (mem_rd_q == rt_n_i);

    fw_cmp_rs = fw_sel(rs_act, ex_rs & ~ex_ld_q,
                       mem_rs & ~(mem_ld_q & MEM_LATE));
    fw_cmp_rt = fw_sel(rt_act, ex_rt & ~ex_ld_q,
                       mem_rt & ~(mem_ld_q & MEM_LATE));

    // Operand produced by a load whose data is not out yet.
    haz_rs = rs_act & ((ex_rs & ex_ld_q) |
                       (mem_rs & mem_ld_q & MEM_LATE));
    haz_rt = rt_act & ((ex_rt & ex_ld_q) |
                       (mem_rt & mem_ld_q & MEM_LATE));

    stall_o = (haz_rs | haz_rt) & ~flush_i;
    bubble  = stall_o | flush_i;
    busy_o  = (state_q == STALL);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      mem_ld_q <= 1'b0;
    end else if (!hold_i) begin
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      mem_ld_q <= ex_ld_q;
      ex_rd_q  <= rd_index_i;
      ex_we_q  <= rd_we_i & ~bubble;
      ex_ld_q  <= rd_ld_i & ~bubble;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      unique case (state_q)
        RUN: begin
          if (stall_o) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
        default: begin
          if (flush_i || cnt_q == 1'b0)
            state_d = RUN;
          else
            cnt_d = cnt_q - 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic        any_fw;

  assign any_fw = (fw_cmp_rs != FW_RF) | (fw_cmp_rt != FW_RF);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!hold_i) begin
      if (stall_o && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (any_fw && fwd_cnt_q != 32'hFFFF_FFFF)
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed + random checks of hazard_ctl (LOAD_LAT 1 and 2)
// against an instruction-history reference model.
module tb_hazard_ctl;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs_n_i, rt_n_i, rd_index_i;
  logic       rs_use_i, rt_use_i;
  logic       rd_we_i, rd_ld_i;
  logic       hold_i, flush_i;

  logic [2:0] fw_rs1, fw_rt1, fw_rs2, fw_rt2;
  logic       st1, bz1, st2, bz2;
`ifdef HAZ_STAT_EN
  logic [31:0] sc1, fc1, sc2, fc2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctl #(.LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst_i(rst_i),
    .rs_n_i(rs_n_i), .rt_n_i(rt_n_i),
    .rs_use_i(rs_use_i), .rt_use_i(rt_use_i),
    .rd_index_i(rd_index_i), .rd_we_i(rd_we_i),
    .rd_ld_i(rd_ld_i), .hold_i(hold_i),
    .flush_i(flush_i),
    .fw_cmp_rs(fw_rs1), .fw_cmp_rt(fw_rt1),
    .stall_o(st1), .busy_o(bz1)
`ifdef HAZ_STAT_EN
    , .stall_cnt_o(sc1), .fwd_cnt_o(fc1)
`endif
  );

  hazard_ctl #(.LOAD_LAT(2)) u_dut2 (
    .clk(clk), .rst_i(rst_i),
    .rs_n_i(rs_n_i), .rt_n_i(rt_n_i),
    .rs_use_i(rs_use_i), .rt_use_i(rt_use_i),
    .rd_index_i(rd_index_i), .rd_we_i(rd_we_i),
    .rd_ld_i(rd_ld_i), .hold_i(hold_i),
    .flush_i(flush_i),
    .fw_cmp_rs(fw_rs2), .fw_cmp_rt(fw_rt2),
    .stall_o(st2), .busy_o(bz2)
`ifdef HAZ_STAT_EN
    , .stall_cnt_o(sc2), .fwd_cnt_o(fc2)
`endif
  );

  // Reference: history of issued instructions, youngest first
  // (age 0 = EX, age 1 = MEM); busy as remaining stall cycles.
  ent_t q1[$];
  ent_t q2[$];
  int   bl[1:2];
  int   msc[1:2];
  int   mfc[1:2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t slot(int l, int age);
    ent_t z = '0;
    if (l == 1)
      return (age < q1.size()) ? q1[age] : z;
    return (age < q2.size()) ? q2[age] : z;
  endfunction

  // Youngest writer whose data is available by its age wins.
  // A load's data is available once age >= LOAD_LAT.
  function automatic logic [2:0] m_fw(int l, logic [4:0] idx, logic en);
    ent_t e;
    if (!en || idx == 0) return 3'd0;
    for (int a = 0; a < 2; a++) begin
      e = slot(l, a);
      if (e.we && e.rd == idx && (!e.ld || a >= l))
        return (a == 0) ? 3'd1 : 3'd2;
    end
    return 3'd0;
  endfunction

  function automatic bit m_haz(int l, logic [4:0] idx, logic en);
    ent_t e;
    if (!en || idx == 0) return 1'b0;
    for (int a = 0; a < 2; a++) begin
      e = slot(l, a);
      if (e.we && e.ld && e.rd == idx && a < l) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_push(int l, ent_t e);
    if (l == 1) begin
      q1.push_front(e);
      if (q1.size() > 2) void'(q1.pop_back());
    end else begin
      q2.push_front(e);
      if (q2.size() > 2) void'(q2.pop_back());
    end
  endtask

  task automatic m_clear();
    q1.delete();
    q2.delete();
    for (int l = 1; l <= 2; l++) begin
      bl[l]  = 0;
      msc[l] = 0;
      mfc[l] = 0;
    end
  endtask

  // Check all outputs against the model, then take one clock edge.
  task automatic cycle();
    logic [2:0] ers[1:2];
    logic [2:0] ert[1:2];
    bit         est[1:2];
    ent_t       n;
    #1;
    for (int l = 1; l <= 2; l++) begin
      ers[l] = m_fw(l, rs_n_i, rs_use_i);
      ert[l] = m_fw(l, rt_n_i, rt_use_i);
      est[l] = (m_haz(l, rs_n_i, rs_use_i) ||
                m_haz(l, rt_n_i, rt_use_i)) && !flush_i;
    end
    chk("u1.fw_rs", fw_rs1, ers[1]);
    chk("u1.fw_rt", fw_rt1, ert[1]);
    chk("u1.stall", st1, est[1]);
    chk("u1.busy", bz1, bl[1] > 0);
    chk("u2.fw_rs", fw_rs2, ers[2]);
    chk("u2.fw_rt", fw_rt2, ert[2]);
    chk("u2.stall", st2, est[2]);
    chk("u2.busy", bz2, bl[2] > 0);
`ifdef HAZ_STAT_EN
    chk("u1.stall_cnt", sc1, msc[1]);
    chk("u1.fwd_cnt", fc1, mfc[1]);
    chk("u2.stall_cnt", sc2, msc[2]);
    chk("u2.fwd_cnt", fc2, mfc[2]);
`endif
    @(posedge clk);
    if (!rst_i && !hold_i) begin
      for (int l = 1; l <= 2; l++) begin
        n = (est[l] || flush_i) ? ent_t'('0)
                                : ent_t'{rd_index_i, rd_we_i, rd_ld_i};
        m_push(l, n);
        if (bl[l] > 0)
          bl[l] = flush_i ? 0 : bl[l] - 1;
        else if (est[l])
          bl[l] = l;
        if (est[l]) msc[l]++;
        if (ers[l] != 0 || ert[l] != 0) mfc[l]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input bit we, input bit ld);
    rs_n_i     = rs;
    rt_n_i     = rt;
    rs_use_i   = 1'b1;
    rt_use_i   = 1'b1;
    rd_index_i = rd;
    rd_we_i    = we;
    rd_ld_i    = ld;
    hold_i     = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m_clear();
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0);
    rst_i = 1'b1;
    m_clear();
    @(negedge clk);
    do_reset();

    // ALU then MEM forwarding
    drv(1, 2, 5, 1, 0);
    cycle();
    drv(5, 0, 0, 0, 0);
    #1;
    chk("alu_fw.rs", fw_rs1, 3'd1);
    chk("alu_fw.stall", st1, 1'b0);
    cycle();
    drv(0, 5, 0, 0, 0);
    #1;
    chk("mem_fw.rt1", fw_rt1, 3'd2);
    chk("mem_fw.rt2", fw_rt2, 3'd2);
    cycle();

    // r0 writer and EX-over-MEM priority
    drv(1, 1, 0, 1, 0);
    cycle();
    drv(0, 0, 9, 1, 0);
    #1;
    chk("r0.rs", fw_rs1, 3'd0);
    cycle();
    drv(1, 1, 9, 1, 0);
    cycle();
    drv(9, 0, 0, 0, 0);
    #1;
    chk("prio.rs", fw_rs1, 3'd1);
    cycle();

    // load-use, hold during STALL, stat counters
    do_reset();
    drv(1, 0, 7, 1, 1);
    cycle();
    drv(7, 7, 0, 0, 0);
    #1;
    chk("lu.stall1", st1, 1'b1);
    chk("lu.stall2", st2, 1'b1);
    cycle();
    #1;
    chk("lu.fw_rs1", fw_rs1, 3'd2);
    chk("lu.fw_rt1", fw_rt1, 3'd2);
    chk("lu.stall1_off", st1, 1'b0);
    chk("lu.stall2_on", st2, 1'b1);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold.stall2", st2, 1'b1);
      chk("hold.busy2", bz2, 1'b1);
    end
    hold_i = 1'b0;
    cycle();
    #1;
    chk("lu.stall2_off", st2, 1'b0);
`ifdef HAZ_STAT_EN
    chk("stat.stall_cnt", sc1, 32'd1);
    chk("stat.fwd_cnt", fc1, 32'd1);
`endif
    cycle();

    // flush wins over a pending hazard
    drv(1, 0, 7, 1, 1);
    cycle();
    drv(7, 7, 9, 1, 0);
    flush_i = 1'b1;
    #1;
    chk("fl.stall1", st1, 1'b0);
    chk("fl.stall2", st2, 1'b0);
    cycle();
    drv(9, 0, 0, 0, 0);
    #1;
    chk("fl.bubble", fw_rs1, 3'd0);
    chk("fl.busy1", bz1, 1'b0);
    cycle();

    // reset in the middle of a stall
    drv(1, 0, 7, 1, 1);
    cycle();
    drv(7, 7, 0, 0, 0);
    cycle();
    rst_i = 1'b1;
    #1;
    chk("rst.stall2", st2, 1'b0);
    chk("rst.busy2", bz2, 1'b0);
    chk("rst.busy1", bz1, 1'b0);
    chk("rst.fw_rs1", fw_rs1, 3'd0);
    chk("rst.fw_rt1", fw_rt1, 3'd0);
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        rs_n_i     = 5'($urandom_range(0, 3));
        rt_n_i     = 5'($urandom_range(0, 3));
        rs_use_i   = 1'($urandom_range(0, 3) != 0);
        rt_use_i   = 1'($urandom_range(0, 3) != 0);
        rd_index_i = 5'($urandom_range(0, 3));
        rd_we_i    = 1'($urandom_range(0, 3) != 0);
        rd_ld_i    = 1'($urandom_range(0, 1));
        hold_i     = 1'($urandom_range(0, 7) == 0);
        flush_i    = !hold_i && ($urandom_range(0, 7) == 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
